// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access sequencer.
package lc3_mem_pkg;

    // Sequencer states: one transaction walks IDLE -> SETUP -> ACCESS (xN) -> DONE -> IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } mem_state_t;

    // Default number of ACCESS cycles per transaction.
    localparam int MEM_WAIT_DEFAULT = 2;

    // Legal bounds for the ACCESS length.
    localparam int MEM_WAIT_MIN = 1;
    localparam int MEM_WAIT_MAX = 15;

endpackage

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access sequencer: turns a one-cycle request into a fixed-timing
// SRAM transaction, captures read data and flags it for the MDR input mux.
//
// Handshake: req is sampled only while idle (busy=0); a request seen then is
// accepted on that edge and the operands are latched. Requests while busy are
// dropped, not queued. done pulses for exactly one cycle when the transaction
// finishes; on a read, rdata is valid and MIO_en is high in that same cycle.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata,
    output logic        MIO_en,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output mem_state_t  dbg_state
);

    // Counter sized to hold WAIT_CYCLES; it counts down from WAIT_CYCLES-1 to 0.
    localparam int            CW        = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);

    // Reject illegal ACCESS lengths when the design is elaborated.
    generate
        if (WAIT_CYCLES < MEM_WAIT_MIN || WAIT_CYCLES > MEM_WAIT_MAX) begin : g_bad_wait
            $error("lc3_mem_ctrl: WAIT_CYCLES=%0d outside legal range 1..15", WAIT_CYCLES);
        end
    endgenerate

    mem_state_t    r_state;
    mem_state_t    w_next_state;
    logic [CW-1:0] r_wait_cnt;
    logic          r_we;
    logic [15:0]   r_addr;
    logic [15:0]   r_wdata;
    logic [15:0]   r_rdata;
    logic          w_accept;
    logic          w_last_access;

    // A request only counts while idle; Reset outranks it in the registers below.
    assign w_accept      = (r_state == IDLE) && req;
    assign w_last_access = (r_state == ACCESS) && (r_wait_cnt == '0);

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and strobes decoded purely from the state register and
    // the latched direction, so nothing on the outputs follows req combinationally.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        MIO_en       = 1'b0;
        mem_ce_n     = 1'b0;
        mem_oe_n     = 1'b1;
        mem_we_n     = 1'b1;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                mem_ce_n = 1'b1;
                if (req) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                mem_oe_n     = r_we;
                w_next_state = ACCESS;
            end
            ACCESS: begin
                mem_oe_n = r_we;
                // Write strobe only here; SETUP and DONE give address/data setup and hold.
                mem_we_n = ~r_we;
                if (r_wait_cnt == '0) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                MIO_en       = ~r_we;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Wait counter: loaded on the way into ACCESS, counts down to zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_wait_cnt <= WAIT_LOAD;
        end else if ((r_state == ACCESS) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - CW'(1);
        end
    end

    // Operand latch on acceptance; values hold through the transaction and in IDLE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_we    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr_in;
            r_wdata <= wdata_in;
        end
    end

    // Read capture on the edge leaving the last ACCESS cycle; writes leave it alone.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rdata <= 16'h0000;
        end else if (w_last_access && !r_we) begin
            r_rdata <= mem_rdata;
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = r_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: default build with an SRAM array model plus
// WAIT_CYCLES=1 and WAIT_CYCLES=15 builds with an address-derived read model.
module tb_lc3_mem_ctrl;
    import lc3_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic Clk;
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic        req, req1, req15;
    logic        we;
    logic [15:0] addr_in, wdata_in;

    // default build
    logic        busy, done, MIO_en, mem_ce_n, mem_oe_n, mem_we_n;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    mem_state_t  dbg_state;

    // WAIT_CYCLES=1 build
    logic        busy1, done1, MIO_en1, mem_ce_n1, mem_oe_n1, mem_we_n1;
    logic [15:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    mem_state_t  dbg_state1;

    // WAIT_CYCLES=15 build
    logic        busy15, done15, MIO_en15, mem_ce_n15, mem_oe_n15, mem_we_n15;
    logic [15:0] rdata15, mem_addr15, mem_wdata15, mem_rdata15;
    mem_state_t  dbg_state15;

    lc3_mem_ctrl #(.WAIT_CYCLES(MEM_WAIT_DEFAULT)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
        .busy(busy), .done(done), .rdata(rdata), .MIO_en(MIO_en),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .dbg_state(dbg_state)
    );

    lc3_mem_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .req(req1), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
        .busy(busy1), .done(done1), .rdata(rdata1), .MIO_en(MIO_en1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
        .mem_ce_n(mem_ce_n1), .mem_oe_n(mem_oe_n1), .mem_we_n(mem_we_n1), .dbg_state(dbg_state1)
    );

    lc3_mem_ctrl #(.WAIT_CYCLES(15)) dut15 (
        .Clk(Clk), .Reset(Reset), .req(req15), .we(we), .addr_in(addr_in), .wdata_in(wdata_in),
        .busy(busy15), .done(done15), .rdata(rdata15), .MIO_en(MIO_en15),
        .mem_addr(mem_addr15), .mem_wdata(mem_wdata15), .mem_rdata(mem_rdata15),
        .mem_ce_n(mem_ce_n15), .mem_oe_n(mem_oe_n15), .mem_we_n(mem_we_n15), .dbg_state(dbg_state15)
    );

    // ---------------- SRAM models ----------------
    logic [15:0] sram [0:65535];
    int          sram_writes = 0;

    assign mem_rdata = (!mem_ce_n && !mem_oe_n) ? sram[mem_addr] : 16'h0000;

    // Asynchronous-style write: a word is written on every edge the strobes are low.
    always @(posedge Clk) begin
        if (!mem_ce_n && !mem_we_n) begin
            sram[mem_addr] <= mem_wdata;
            sram_writes    <= sram_writes + 1;
        end
    end

    assign mem_rdata1  = (!mem_ce_n1 && !mem_oe_n1) ? (mem_addr1 ^ 16'hA5A5) : 16'h0000;
    assign mem_rdata15 = (!mem_ce_n15 && !mem_oe_n15) ? (mem_addr15 ^ 16'hA5A5) : 16'h0000;

    // ---------------- scoreboard ----------------
    // Entry = {expected MIO_en, expected rdata} at the done pulse.
    logic [16:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [16:0] e;
        check({tag, "_queue_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_mio_rdata"}, {15'd0, MIO_en, rdata}, {15'd0, e});
        end
    endtask

    // Drive one request for one cycle; returns just after the accepting edge.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d);
        we       = w;
        addr_in  = a;
        wdata_in = d;
        req      = 1'b1;
        tick();
        req      = 1'b0;
    endtask

    // Follow the default-build transaction from the accepting edge back to IDLE.
    task automatic follow(input string tag, input logic [15:0] a,
                          output int oe_cnt, output int we_cnt, output int we_setup, output int lat);
        oe_cnt   = 0;
        we_cnt   = 0;
        we_setup = 0;
        lat      = -1;
        check({tag, "_addr_latched"}, {16'd0, mem_addr}, {16'd0, a});
        for (int c = 0; c < 40; c++) begin
            if (!mem_oe_n) oe_cnt++;
            if (!mem_we_n) begin
                we_cnt++;
                if (dbg_state == SETUP) we_setup++;
            end
            if (done) begin
                lat = c;
                pop_check(tag);
            end
            if (!busy) break;
            tick();
        end
        check({tag, "_back_to_idle"}, {31'd0, busy}, 32'd0);
    endtask

    int oe_cnt, we_cnt, we_setup, lat, w0, acc_n, acc_first, acc_second, gap_idle, lat1, oe1, wl1;

    initial begin
        Reset    = 1'b1;
        req      = 1'b0;
        req1     = 1'b0;
        req15    = 1'b0;
        we       = 1'b0;
        addr_in  = 16'h0000;
        wdata_in = 16'h0000;
        sram[16'h3000] <= 16'h1234;
        tick();
        tick();

        // Reset state
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_flags", {29'd0, busy, done, MIO_en}, 32'd0);
        check("rst_strobes", {29'd0, mem_ce_n, mem_oe_n, mem_we_n}, 32'd7);
        check("rst_addr_wdata", {mem_addr, mem_wdata}, 32'd0);
        check("rst_rdata", {16'd0, rdata}, 32'd0);
        check("rst_strobes_w15", {29'd0, mem_ce_n15, mem_oe_n15, mem_we_n15}, 32'd7);
        Reset = 1'b0;
        tick();

        // Read 0x3000 -> 0x1234
        exp_q.push_back({1'b1, 16'h1234});
        issue(1'b0, 16'h3000, 16'h0000);
        check("rd_setup_state", 32'(dbg_state), 32'(SETUP));
        check("rd_setup_busy_ce", {30'd0, busy, mem_ce_n}, 32'd2);
        follow("rd", 16'h3000, oe_cnt, we_cnt, we_setup, lat);
        check("rd_oe_cycles", 32'(oe_cnt), 32'd3);
        check("rd_no_we", 32'(we_cnt), 32'd0);
        check("rd_done_latency", 32'(lat), 32'd3);
        check("rd_rdata_hold", {16'd0, rdata}, 32'h1234);
        check("rd_idle_mio", {31'd0, MIO_en}, 32'd0);

        // Write 0xBEEF to 0x4001; rdata must keep 0x1234
        w0 = sram_writes;
        exp_q.push_back({1'b0, 16'h1234});
        issue(1'b1, 16'h4001, 16'hBEEF);
        check("wr_wdata_latched", {16'd0, mem_wdata}, 32'hBEEF);
        follow("wr", 16'h4001, oe_cnt, we_cnt, we_setup, lat);
        check("wr_we_cycles", 32'(we_cnt), 32'd2);
        check("wr_we_in_setup", 32'(we_setup), 32'd0);
        check("wr_no_oe", 32'(oe_cnt), 32'd0);
        check("wr_done_latency", 32'(lat), 32'd3);
        check("wr_sram_word", {16'd0, sram[16'h4001]}, 32'hBEEF);
        check("wr_sram_edges", 32'(sram_writes - w0), 32'd2);
        check("wr_addr_hold_idle", {16'd0, mem_addr}, 32'h4001);

        // Back-to-back: a single read, then req raised in its last ACCESS cycle
        // and held for 12 edges (two of them fall in ACCESS/DONE and are ignored).
        exp_q.push_back({1'b1, 16'h1234});
        exp_q.push_back({1'b1, 16'hBEEF});
        exp_q.push_back({1'b1, 16'hBEEF});
        issue(1'b0, 16'h3000, 16'h0000);
        tick();
        tick();
        we         = 1'b0;
        addr_in    = 16'h4001;
        req        = 1'b1;
        acc_n      = 0;
        acc_first  = -1;
        acc_second = -1;
        gap_idle   = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dbg_state == SETUP) begin
                acc_n++;
                if (acc_first < 0) acc_first = i;
                else if (acc_second < 0) acc_second = i;
            end
            if (acc_first >= 0 && acc_second < 0 && !busy) gap_idle++;
            if (done) pop_check("b2b");
        end
        req = 1'b0;
        check("b2b_accept_count", 32'(acc_n), 32'd2);
        check("b2b_first_after_done", 32'(acc_first), 32'd2);
        check("b2b_spacing", 32'(acc_second - acc_first), 32'd5);
        check("b2b_idle_gap", 32'(gap_idle), 32'd1);
        tick();
        check("b2b_idle_after", {31'd0, busy}, 32'd0);

        // Reset in the first ACCESS cycle of a write
        issue(1'b1, 16'h5000, 16'hCAFE);
        tick();
        check("rstw_in_access", 32'(dbg_state), 32'(ACCESS));
        Reset = 1'b1;
        tick();
        w0 = sram_writes;
        check("rstw_strobes", {29'd0, mem_ce_n, mem_oe_n, mem_we_n}, 32'd7);
        check("rstw_busy", {31'd0, busy}, 32'd0);
        check("rstw_state", 32'(dbg_state), 32'(IDLE));
        check("rstw_addr_rdata", {mem_addr, rdata}, 32'd0);
        Reset = 1'b0;
        tick();
        tick();
        tick();
        check("rstw_no_more_writes", 32'(sram_writes - w0), 32'd0);
        check("rstw_still_idle", {31'd0, busy}, 32'd0);

        // Reset and req together: request must be dropped
        we      = 1'b0;
        addr_in = 16'h3000;
        Reset   = 1'b1;
        req     = 1'b1;
        tick();
        check("rstreq_busy", {31'd0, busy}, 32'd0);
        check("rstreq_state", 32'(dbg_state), 32'(IDLE));
        Reset = 1'b0;
        req   = 1'b0;
        tick();
        check("rstreq_busy_after", {31'd0, busy}, 32'd0);

        // WAIT_CYCLES=1 build
        we       = 1'b0;
        addr_in  = 16'h0123;
        wdata_in = 16'h7777;
        req1     = 1'b1;
        tick();
        req1 = 1'b0;
        check("w1_wdata_latched", {16'd0, mem_wdata1}, 32'h7777);
        lat1 = -1;
        oe1  = 0;
        wl1  = 0;
        for (int c = 0; c < 40; c++) begin
            if (!mem_oe_n1) oe1++;
            if (!mem_we_n1) wl1++;
            if (done1) begin
                lat1 = c;
                check("w1_rdata", {16'd0, rdata1}, {16'd0, 16'h0123 ^ 16'hA5A5});
                check("w1_mio", {31'd0, MIO_en1}, 32'd1);
            end
            if (!busy1) break;
            tick();
        end
        check("w1_latency", 32'(lat1), 32'd2);
        check("w1_oe_cycles", 32'(oe1), 32'd2);
        check("w1_no_we", 32'(wl1), 32'd0);
        check("w1_idle", {30'd0, dbg_state1}, 32'(IDLE));
        check("w1_ce_idle", {31'd0, mem_ce_n1}, 32'd1);
        check("w1_rdata_hold", {16'd0, rdata1}, {16'd0, 16'h0123 ^ 16'hA5A5});

        // WAIT_CYCLES=15 build
        addr_in  = 16'hF00D;
        wdata_in = 16'h1111;
        req15    = 1'b1;
        tick();
        req15 = 1'b0;
        check("w15_wdata_latched", {16'd0, mem_wdata15}, 32'h1111);
        lat1 = -1;
        oe1  = 0;
        wl1  = 0;
        for (int c = 0; c < 60; c++) begin
            if (!mem_oe_n15) oe1++;
            if (!mem_we_n15) wl1++;
            if (done15) begin
                lat1 = c;
                check("w15_rdata", {16'd0, rdata15}, {16'd0, 16'hF00D ^ 16'hA5A5});
                check("w15_mio", {31'd0, MIO_en15}, 32'd1);
            end
            if (!busy15) break;
            tick();
        end
        check("w15_latency", 32'(lat1), 32'd16);
        check("w15_oe_cycles", 32'(oe1), 32'd16);
        check("w15_no_we", 32'(wl1), 32'd0);
        check("w15_idle", {30'd0, dbg_state15}, 32'(IDLE));
        check("w15_ce_idle", {31'd0, mem_ce_n15}, 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
